// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM states and port slicing.
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Lowest bit of port idx inside a flattened bus of width-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Reset-driven clear sequencer: zeroes one register-file entry per cycle after rst.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t       state, state_nxt;
    logic [AW-1:0]   clr_ptr, clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // The last entry is written in the same cycle the FSM returns to RUN.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        if (state == RF_CLEAR && !rst) begin
            clr_we      = 1'b1;
            clr_ptr_nxt = clr_ptr + 1'b1;
            if (clr_ptr == LAST) begin
                state_nxt = RF_RUN;
            end
        end
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD combinational read ports, two write ports, debug read port.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 32,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [AW-1:0]     dbg_ra,
    output logic [DW-1:0]     dbg_rd,
    output logic              busy
);

    logic [DW-1:0] rf [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr0_en, wr1_en;

    rf_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write enable here means the write really commits at the next edge.
    always_comb begin
        wr0_en = we0 && !busy && !rst && !(ZERO_R0 != 0 && wa0 == '0);
        wr1_en = we1 && !busy && !rst && !(ZERO_R0 != 0 && wa1 == '0);
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_addr] <= '0;
        end else begin
            if (wr0_en && !(wr1_en && wa1 == wa0)) begin
                rf[wa0] <= wd0;
            end
            if (wr1_en) begin
                rf[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        assign addr = ra[slice_lo(i, AW) +: AW];

        always_comb begin
            data = rf[addr];
`ifdef RF_BYPASS_EN
            if (wr0_en && wa0 == addr) begin
                data = wd0;
            end
            if (wr1_en && wa1 == addr) begin
                data = wd1;
            end
`endif
            if (ZERO_R0 != 0 && addr == '0) begin
                data = '0;
            end
        end

        assign rd[slice_lo(i, DW) +: DW] = data;
    end

    assign dbg_rd = (ZERO_R0 != 0 && dbg_ra == '0) ? '0 : rf[dbg_ra];

endmodule
